// File: rtl/perm_key_sweeper.sv
// Job front-end for the XOR-permutation stage: latches one word, then walks the
// permutation key through a run of consecutive values, optionally settling before each.
module perm_key_sweeper #(
  parameter int N_IN   = 64,
  parameter int PERMB  = $clog2(N_IN),
  parameter int SETTLE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N_IN-1:0]  s_data,
  input  logic [PERMB-1:0] s_key_start,
  input  logic [PERMB:0]   s_key_count,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_IN-1:0]  m_data,
  output logic [PERMB-1:0] m_key,
  output logic             m_last,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PRESENT} state_t;

  localparam logic [PERMB:0] CNT_FULL = {1'b1, {PERMB{1'b0}}};
  localparam logic [PERMB:0] CNT_ONE  = (PERMB+1)'(1);
  localparam logic [PERMB:0] CNT_TWO  = (PERMB+1)'(2);
  localparam logic [7:0]     SETTLE_LOAD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

  state_t           state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic [N_IN-1:0]  m_data_q, m_data_d;
  logic [PERMB-1:0] m_key_q, m_key_d;
  logic [PERMB:0]   remaining_q, remaining_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic [PERMB:0]   eff_count;

  // Zero and anything beyond the key space both mean "every key once".
  assign eff_count = ((s_key_count == '0) || (s_key_count > CNT_FULL)) ? CNT_FULL : s_key_count;

  always_comb begin
    state_d      = state_q;
    s_ready_d    = s_ready_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    busy_d       = busy_q;
    m_data_d     = m_data_q;
    m_key_d      = m_key_q;
    remaining_d  = remaining_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          m_data_d    = s_data;
          m_key_d     = s_key_start;
          remaining_d = eff_count;
          s_ready_d   = 1'b0;
          busy_d      = 1'b1;
          if (SETTLE == 0) begin
            state_d   = ST_PRESENT;
            m_valid_d = 1'b1;
            m_last_d  = (eff_count == CNT_ONE);
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 8'd0) begin
          state_d   = ST_PRESENT;
          m_valid_d = 1'b1;
          m_last_d  = (remaining_q == CNT_ONE);
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      ST_PRESENT: begin
        if (m_ready) begin
          if (remaining_q == CNT_ONE) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            busy_d    = 1'b0;
            s_ready_d = 1'b1;
          end else begin
            m_key_d     = m_key_q + PERMB'(1);
            remaining_d = remaining_q - CNT_ONE;
            if (SETTLE == 0) begin
              // Back-to-back keys: the next one is last when two remain now.
              m_last_d = (remaining_q == CNT_TWO);
            end else begin
              state_d      = ST_SETTLE;
              m_valid_d    = 1'b0;
              m_last_d     = 1'b0;
              settle_cnt_d = SETTLE_LOAD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      m_data_q     <= '0;
      m_key_q      <= '0;
      remaining_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      busy_q       <= busy_d;
      m_data_q     <= m_data_d;
      m_key_q      <= m_key_d;
      remaining_q  <= remaining_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign m_data  = m_data_q;
  assign m_key   = m_key_q;

endmodule
